axi_lite_mem_bank: RTL

//  Parametrised AXI4-Lite slave memory bank for PCA bring-up and host-register tests. Successor to the fixed 32-bit test memory.

---
 rtl/axi_lite_mem_bank.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_mem_bank.sv
// rtl/axi_lite_mem_bank.sv - AXI4-Lite slave memory bank with strobed writes, OOR errors, read latency and counters
//
// Ports:
//   s_axi_aclk_i / s_axi_aresetn_i      clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*                     write address, write data and write response channels
//   s_axi_ar*/r*                        read address and read data channels
//   cnt_clr_i                           synchronous clear of all statistics counters
//   wr_count_o/rd_count_o/err_count_o   saturating B, R and SLVERR handshake counters
module axi_lite_mem_bank #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 24,
    parameter int DEPTH      = 1024,
    parameter int RD_LAT     = 1,
    parameter int ERR_ON_OOR = 1,
    parameter int CNT_W      = 32
) (
    input  logic                s_axi_aclk_i,
    input  logic                s_axi_aresetn_i,
    input  logic [ADDR_W-1:0]   s_axi_awaddr_i,
    input  logic                s_axi_awvalid_i,
    output logic                s_axi_awready_o,
    input  logic [DATA_W-1:0]   s_axi_wdata_i,
    input  logic [DATA_W/8-1:0] s_axi_wstrb_i,
    input  logic                s_axi_wvalid_i,
    output logic                s_axi_wready_o,
    output logic [1:0]          s_axi_bresp_o,
    output logic                s_axi_bvalid_o,
    input  logic                s_axi_bready_i,
    input  logic [ADDR_W-1:0]   s_axi_araddr_i,
    input  logic                s_axi_arvalid_i,
    output logic                s_axi_arready_o,
    output logic [DATA_W-1:0]   s_axi_rdata_o,
    output logic [1:0]          s_axi_rresp_o,
    output logic                s_axi_rvalid_o,
    input  logic                s_axi_rready_i,
    input  logic                cnt_clr_i,
    output logic [CNT_W-1:0]    wr_count_o,
    output logic [CNT_W-1:0]    rd_count_o,
    output logic [CNT_W-1:0]    err_count_o
);
    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              aw_full_q, aw_full_d, awready_q, awready_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic              w_full_q, w_full_d, wready_q, wready_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [BYTES-1:0]  w_strb_q, w_strb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rd_busy_q, rd_busy_d, arready_q, arready_d;
    logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;
    logic [DATA_W-1:0] pipe_data_q [RD_LAT];
    logic [DATA_W-1:0] pipe_data_d [RD_LAT];
    logic [1:0]        pipe_resp_q [RD_LAT];
    logic [1:0]        pipe_resp_d [RD_LAT];
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;

    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, wr_oor, ar_oor;
    logic [IDX_W-1:0]  ar_idx;
    logic [DATA_W-1:0] rd_word;
    logic [1:0]        err_inc;
    logic [RD_LAT-1:0] chain_v;
    logic [DATA_W-1:0] chain_data [RD_LAT];
    logic [1:0]        chain_resp [RD_LAT];
    logic              unused_addr_bits;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
        logic [CNT_W+1:0] sum;
        sum = {2'b00, c} + {{CNT_W{1'b0}}, inc};
        return (sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    assign unused_addr_bits = ^{s_axi_awaddr_i[OFF_W-1:0], s_axi_araddr_i[OFF_W-1:0]};

    assign aw_hs  = s_axi_awvalid_i & awready_q;
    assign w_hs   = s_axi_wvalid_i & wready_q;
    assign b_hs   = bvalid_q & s_axi_bready_i;
    assign ar_hs  = s_axi_arvalid_i & arready_q;
    assign r_hs   = pipe_v_q[RD_LAT-1] & s_axi_rready_i;
    // A commit may reuse the B slot in the very cycle the previous response is accepted.
    assign commit = aw_full_q & w_full_q & (~bvalid_q | s_axi_bready_i);

    // Extra leading zero so DEPTH == 2**IDX_W does not truncate to zero.
    assign wr_oor  = (ERR_ON_OOR != 0) && ({1'b0, aw_idx_q} >= (IDX_W+1)'(DEPTH));
    assign ar_idx  = s_axi_araddr_i[ADDR_W-1:OFF_W];
    assign ar_oor  = (ERR_ON_OOR != 0) && ({1'b0, ar_idx} >= (IDX_W+1)'(DEPTH));
    // Combinational read sampled on the AR edge sees the array before a same-edge commit.
    assign rd_word = mem[ar_idx[MEM_AW-1:0]];
    assign err_inc = {1'b0, b_hs & bresp_q[1]} + {1'b0, r_hs & pipe_resp_q[RD_LAT-1][1]};

    always_comb begin
        chain_v       = '0;
        chain_v[0]    = ar_hs;
        chain_data[0] = ar_oor ? '0 : rd_word;
        chain_resp[0] = ar_oor ? RESP_SLVERR : RESP_OKAY;
        for (int k = 1; k < RD_LAT; k++) begin
            chain_v[k]    = pipe_v_q[k-1];
            chain_data[k] = pipe_data_q[k-1];
            chain_resp[k] = pipe_resp_q[k-1];
        end
    end

    always_comb begin
        aw_full_d   = aw_full_q;
        aw_idx_d    = aw_idx_q;
        w_full_d    = w_full_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rd_busy_d   = rd_busy_q;
        pipe_v_d    = pipe_v_q;
        pipe_data_d = pipe_data_q;
        pipe_resp_d = pipe_resp_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi_awaddr_i[ADDR_W-1:OFF_W];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata_i;
            w_strb_d = s_axi_wstrb_i;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_oor ? RESP_SLVERR : RESP_OKAY;
        end else if (b_hs) begin
            bvalid_d = 1'b0;
        end
        awready_d = ~aw_full_d;
        wready_d  = ~w_full_d;

        if (ar_hs) begin
            rd_busy_d = 1'b1;
        end else if (r_hs) begin
            rd_busy_d = 1'b0;
        end
        arready_d = ~rd_busy_d;

        // Only one read is ever in flight, so intermediate stages shift freely and
        // the output stage only has to hold until the R handshake.
        for (int k = 0; k < RD_LAT - 1; k++) begin
            pipe_v_d[k]    = chain_v[k];
            pipe_data_d[k] = chain_data[k];
            pipe_resp_d[k] = chain_resp[k];
        end
        if (chain_v[RD_LAT-1]) begin
            pipe_v_d[RD_LAT-1]    = 1'b1;
            pipe_data_d[RD_LAT-1] = chain_data[RD_LAT-1];
            pipe_resp_d[RD_LAT-1] = chain_resp[RD_LAT-1];
        end else if (r_hs) begin
            pipe_v_d[RD_LAT-1] = 1'b0;
        end

        if (cnt_clr_i) begin
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            err_cnt_d = '0;
        end else begin
            wr_cnt_d  = sat_add(wr_cnt_q, {1'b0, b_hs});
            rd_cnt_d  = sat_add(rd_cnt_q, {1'b0, r_hs});
            err_cnt_d = sat_add(err_cnt_q, err_inc);
        end
    end

    always_ff @(posedge s_axi_aclk_i or negedge s_axi_aresetn_i) begin
        if (!s_axi_aresetn_i) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            awready_q <= 1'b0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rd_busy_q <= 1'b0;
            arready_q <= 1'b0;
            pipe_v_q  <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_data_q[k] <= '0;
                pipe_resp_q[k] <= RESP_OKAY;
            end
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            awready_q <= awready_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rd_busy_q <= rd_busy_d;
            arready_q <= arready_d;
            pipe_v_q  <= pipe_v_d;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_data_q[k] <= pipe_data_d[k];
                pipe_resp_q[k] <= pipe_resp_d[k];
            end
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Array is never reset; commit is already gated low while reset is asserted.
    always_ff @(posedge s_axi_aclk_i) begin
        if (commit && !wr_oor) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_strb_q[b]) begin
                    mem[aw_idx_q[MEM_AW-1:0]][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    assign s_axi_awready_o = awready_q;
    assign s_axi_wready_o  = wready_q;
    assign s_axi_bvalid_o  = bvalid_q;
    assign s_axi_bresp_o   = bresp_q;
    assign s_axi_arready_o = arready_q;
    assign s_axi_rvalid_o  = pipe_v_q[RD_LAT-1];
    assign s_axi_rdata_o   = pipe_data_q[RD_LAT-1];
    assign s_axi_rresp_o   = pipe_resp_q[RD_LAT-1];
    assign wr_count_o      = wr_cnt_q;
    assign rd_count_o      = rd_cnt_q;
    assign err_count_o     = err_cnt_q;
endmodule
